// File: rtl/uart_rx_monitor_pkg.sv
// Shared definitions for the UART receive monitor.
//   rx_state_e      : receive FSM state encoding
//   CMD_*           : ESC-prefixed control byte values understood by the decoder
package uart_rx_monitor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  localparam logic [7:0] CMD_ESC     = 8'h1B;
  localparam logic [7:0] CMD_DBG_EN  = 8'h11;
  localparam logic [7:0] CMD_DBG_DIS = 8'h12;
  localparam logic [7:0] CMD_SIM_END = 8'h04;

endpackage

// File: rtl/uart_rx_monitor_if.sv
// Byte stream handshake between the UART monitor and its consumer.
//   RX_DATA  : head byte of the receive FIFO
//   RX_VALID : FIFO non-empty
//   RX_READY : consumer pops the head when high together with RX_VALID
// master = the monitor (producer), slave = the logger/checker (consumer).
interface uart_rx_monitor_if;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_READY;

  modport master (output RX_DATA, output RX_VALID, input RX_READY);
  modport slave  (input RX_DATA, input RX_VALID, output RX_READY);
endinterface

// File: rtl/uart_rx_monitor_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy and overrun.
//   clk, rst_n : clock, async active-low reset
//   push       : write request, push_data the byte to store
//   pop_req    : consumer ready; a pop happens when valid && pop_req
//   rdata      : head byte (mem[rd_ptr]), valid : count != 0
//   count      : occupancy 0..DEPTH
//   overrun    : single-cycle pulse when a push is rejected (FIFO full, no pop)
module uart_rx_monitor_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop_req,
  output logic [7:0]    rdata,
  output logic          valid,
  output logic [AW:0]   count,
  output logic          overrun
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pop, push_ok;

  always_comb begin
    pop      = (count_q != '0) && pop_req;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push_ok  = push && ((count_q < DEPTH_C) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers alone define
  // which entries are meaningful, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign rdata   = mem_q[rd_ptr_q];
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign overrun = push && !push_ok;

endmodule

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receive monitor for the MCU stdout line.
//   CLK, RESETn          : clock, async active-low reset
//   RXD                  : serial input, idle high, asynchronous to CLK
//   rx_if (master)       : RX_DATA / RX_VALID / RX_READY byte stream out of the FIFO
//   FIFO_COUNT           : FIFO occupancy
//   OVERRUN, FRAME_ERR   : sticky error flags, cleared by CLR_ERR (set wins)
//   DEBUG_TESTER_ENABLE  : ESC 0x11 sets, ESC 0x12 clears
//   SIMULATIONEND        : ESC 0x04 sets, only reset clears
// Bytes are sampled mid-bit with a down counter; completed bytes pass through
// an ESC command decoder and ordinary bytes are pushed into the FIFO.
module uart_rx_monitor
  import uart_rx_monitor_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3
) (
  input  logic               CLK,
  input  logic               RESETn,
  input  logic               RXD,
  uart_rx_monitor_if.master  rx_if,
  output logic [FIFO_AW:0]   FIFO_COUNT,
  output logic               OVERRUN,
  output logic               FRAME_ERR,
  input  logic               CLR_ERR,
  output logic               DEBUG_TESTER_ENABLE,
  output logic               SIMULATIONEND
);

  localparam int              CW      = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]   HALF_M1 = CW'(BAUD_DIV/2 - 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(BAUD_DIV - 1);

  // Two-flop synchroniser; reset high so an idle line sees no false start.
  logic rxd_meta_q, rxd_s_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= RXD;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // ---------------- receive FSM ----------------
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          expiry;
  logic          byte_done, frame_err_set;

  assign expiry = (cnt_q == '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values present before the edge.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (!rxd_s_q) begin
          state_d = ST_START;
          cnt_d   = HALF_M1;   // first sample lands mid start bit
        end
      end
      ST_START: if (expiry) begin
        cnt_d = FULL_M1;
        if (rxd_s_q) state_d = ST_IDLE;   // glitch, not a start bit
        else begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: if (expiry) begin
        cnt_d   = FULL_M1;
        shift_d = {rxd_s_q, shift_q[7:1]};   // LSB first
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: if (expiry) begin
        cnt_d   = FULL_M1;
        state_d = rxd_s_q ? ST_IDLE : ST_BRK_WAIT;
      end
      ST_BRK_WAIT: begin
        cnt_d = cnt_q;
        if (rxd_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_done     = (state_q == ST_STOP) && expiry &&  rxd_s_q;
    frame_err_set = (state_q == ST_STOP) && expiry && !rxd_s_q;
  end

  // ---------------- command decoder ----------------
  logic esc_q, esc_d, dbg_q, dbg_d, sim_q, sim_d;
  logic push;

  always_comb begin
    esc_d = esc_q;
    dbg_d = dbg_q;
    sim_d = sim_q;
    push  = 1'b0;
    if (byte_done) begin
      if (!esc_q) begin
        if (shift_q == CMD_ESC) esc_d = 1'b1;
        else                    push  = 1'b1;
      end else begin
        esc_d = 1'b0;
        case (shift_q)
          CMD_DBG_EN:  dbg_d = 1'b1;
          CMD_DBG_DIS: dbg_d = 1'b0;
          CMD_SIM_END: sim_d = 1'b1;
          default:     push  = 1'b1;   // includes ESC ESC -> literal 0x1B
        endcase
      end
    end
  end

  // ---------------- FIFO and sticky errors ----------------
  logic fifo_overrun;
  logic ovr_q, ovr_d, ferr_q, ferr_d;

  uart_rx_monitor_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (push),
    .push_data (shift_q),
    .pop_req   (rx_if.RX_READY),
    .rdata     (rx_if.RX_DATA),
    .valid     (rx_if.RX_VALID),
    .count     (FIFO_COUNT),
    .overrun   (fifo_overrun)
  );

  always_comb begin
    ovr_d  = (ovr_q  && !CLR_ERR) || fifo_overrun;
    ferr_d = (ferr_q && !CLR_ERR) || frame_err_set;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      esc_q  <= 1'b0;
      dbg_q  <= 1'b0;
      sim_q  <= 1'b0;
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      esc_q  <= esc_d;
      dbg_q  <= dbg_d;
      sim_q  <= sim_d;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  assign OVERRUN             = ovr_q;
  assign FRAME_ERR           = ferr_q;
  assign DEBUG_TESTER_ENABLE = dbg_q;
  assign SIMULATIONEND       = sim_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Self-checking bench for uart_rx_monitor (BAUD_DIV=16, 8-entry FIFO).
// Serial frames are driven bit by bit; a byte-level model (expected queue
// plus flag variables) predicts FIFO contents and control outputs.
module tb_uart_rx_monitor;

  localparam int BD = 16;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       RXD;
  logic       CLR_ERR;
  logic [3:0] FIFO_COUNT;
  logic       OVERRUN, FRAME_ERR, DEBUG_TESTER_ENABLE, SIMULATIONEND;

  uart_rx_monitor_if rx_if ();

  uart_rx_monitor #(.BAUD_DIV(BD), .FIFO_DEPTH(8), .FIFO_AW(3)) dut (
    .CLK                 (CLK),
    .RESETn              (RESETn),
    .RXD                 (RXD),
    .rx_if               (rx_if),
    .FIFO_COUNT          (FIFO_COUNT),
    .OVERRUN             (OVERRUN),
    .FRAME_ERR           (FRAME_ERR),
    .CLR_ERR             (CLR_ERR),
    .DEBUG_TESTER_ENABLE (DEBUG_TESTER_ENABLE),
    .SIMULATIONEND       (SIMULATIONEND)
  );

  always #5 CLK = ~CLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [7:0] exp_q[$];
  bit         m_esc, m_dbg, m_sim, m_ovr, m_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_esc = 0; m_dbg = 0; m_sim = 0; m_ovr = 0; m_ferr = 0;
  endtask

  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() >= 8) m_ovr = 1;
    else exp_q.push_back(b);
  endtask

  // Decoder rules applied per received byte (consumer not popping).
  task automatic model_byte(input logic [7:0] b);
    if (!m_esc) begin
      if (b == 8'h1B) m_esc = 1;
      else model_push(b);
    end else begin
      m_esc = 0;
      if      (b == 8'h11) m_dbg = 1;
      else if (b == 8'h12) m_dbg = 0;
      else if (b == 8'h04) m_sim = 1;
      else model_push(b);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (BD) @(posedge CLK);
    for (int i = 0; i < 8; i++) begin
      #1 RXD = b[i];
      repeat (BD) @(posedge CLK);
    end
    #1 RXD = stop_bit;
    repeat (BD) @(posedge CLK);
    if (stop_bit) begin
      #1 RXD = 1'b1;
      repeat (4) @(posedge CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1);
    model_byte(b);
  endtask

  task automatic check_flags(input string tag);
    @(negedge CLK);
    check({tag, "_dbg"},  DEBUG_TESTER_ENABLE, m_dbg);
    check({tag, "_sim"},  SIMULATIONEND,       m_sim);
    check({tag, "_ovr"},  OVERRUN,             m_ovr);
    check({tag, "_ferr"}, FRAME_ERR,           m_ferr);
    check({tag, "_cnt"},  FIFO_COUNT,          exp_q.size());
  endtask

  // Pops every modelled byte, checking head data before each pop.
  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge CLK);
      check({tag, "_valid"}, rx_if.RX_VALID, 1'b1);
      check({tag, "_data"},  rx_if.RX_DATA,  e);
      @(posedge CLK); #1 rx_if.RX_READY = 1'b1;
      @(posedge CLK); #1 rx_if.RX_READY = 1'b0;
    end
    @(negedge CLK);
    check({tag, "_empty"}, {FIFO_COUNT, rx_if.RX_VALID}, 5'd0);
  endtask

  task automatic pulse_clr();
    @(posedge CLK); #1 CLR_ERR = 1'b1;
    @(posedge CLK); #1 CLR_ERR = 1'b0;
    m_ovr = 0; m_ferr = 0;
  endtask

  int         lat;
  logic [7:0] b;
  int         nb;

  initial begin
    RESETn = 1'b0; RXD = 1'b1; CLR_ERR = 1'b0; rx_if.RX_READY = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outs", {OVERRUN, FRAME_ERR, DEBUG_TESTER_ENABLE, SIMULATIONEND, rx_if.RX_VALID}, 5'd0);
    check("reset_cnt", FIFO_COUNT, 4'd0);
    #1 RESETn = 1'b1;
    repeat (4) @(posedge CLK);

    // 1) Single byte with consumer ready: latency and one-cycle valid pulse.
    rx_if.RX_READY = 1'b1;
    lat = -1;
    fork
      send_frame(8'h41, 1'b1);
      begin
        @(posedge CLK);   // RXD falls just after this edge; next edge is k
        for (int n = 0; n < 300; n++) begin
          @(posedge CLK);
          @(negedge CLK);
          if (rx_if.RX_VALID) begin
            lat = n;
            check("t1_data", rx_if.RX_DATA, 8'h41);
            break;
          end
        end
        check("t1_latency", lat, 154);
        @(negedge CLK);
        check("t1_pulse", rx_if.RX_VALID, 1'b0);
      end
    join
    check("t1_cnt", FIFO_COUNT, 4'd0);
    rx_if.RX_READY = 1'b0;

    // 2) ESC command sequences.
    send_byte(8'h1B); send_byte(8'h11);
    check_flags("esc_en");
    check("esc_en_dbg1", DEBUG_TESTER_ENABLE, 1'b1);
    send_byte(8'h1B); send_byte(8'h12);
    check_flags("esc_dis");
    send_byte(8'h1B); send_byte(8'h1B);
    send_byte(8'h1B); send_byte(8'h04);
    check_flags("esc_end");
    check("esc_one_push", FIFO_COUNT, 4'd1);
    drain("esc");
    check("esc_sim_stays", SIMULATIONEND, 1'b1);

    // 3) Overrun: nine bytes, consumer stalled.
    for (int i = 0; i < 9; i++) send_byte(8'(i));
    check_flags("ovr");
    // Head must hold steady while not ready.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("ovr_hold", rx_if.RX_DATA, 8'h00);
    drain("ovr");
    pulse_clr();
    check_flags("ovr_clr");

    // 4) Random byte bursts, including command bytes.
    for (int r = 0; r < 4; r++) begin
      nb = $urandom_range(8, 1);
      for (int i = 0; i < nb; i++) begin
        case ($urandom_range(5, 0))
          0: b = 8'h1B;
          1: b = 8'h11;
          2: b = 8'h12;
          default: b = 8'($urandom);
        endcase
        send_byte(b);
      end
      check_flags("rnd");
      drain("rnd");
    end

    // 5) Stop bit low, line held low 40 bits, then a good byte.
    send_frame(8'h5A, 1'b0);
    m_ferr = 1;
    check_flags("ferr_set");
    pulse_clr();
    repeat (40 * BD) @(posedge CLK);
    #1 RXD = 1'b1;
    repeat (2 * BD) @(posedge CLK);
    check_flags("ferr_once");
    send_byte(8'h55);
    check_flags("ferr_after");
    drain("ferr");

    // 6) Four-cycle low glitch.
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (4) @(posedge CLK);
    #1 RXD = 1'b1;
    repeat (3 * BD) @(posedge CLK);
    check_flags("glitch");

    // 7) Reset in the middle of 0x3C, then 0xA5.
    b = 8'h3C;
    @(posedge CLK); #1 RXD = 1'b0;
    repeat (BD) @(posedge CLK);
    for (int i = 0; i < 5; i++) begin
      #1 RXD = b[i];
      repeat (BD) @(posedge CLK);
    end
    #1 RESETn = 1'b0;
    model_reset();
    @(negedge CLK);
    check("mid_reset_outs", {OVERRUN, FRAME_ERR, DEBUG_TESTER_ENABLE, SIMULATIONEND, rx_if.RX_VALID}, 5'd0);
    #1 RXD = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    repeat (3 * BD) @(posedge CLK);
    check_flags("post_reset_idle");
    send_byte(8'hA5);
    check_flags("post_reset");
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no_finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
Simulation-side UART receiver that consumes the MCU stdout TXD line (P1[5]) in the M0 testbench. It deserialises 8N1 frames and decodes ESC-prefixed control commands that drive the debug-tester enable and end-of-simulation flags. Ordinary bytes go into a small FIFO that a bench logger or checker drains through a valid/ready handshake.

Parameters:
BAUD_DIV, 16, CLK cycles per bit (even, >=4).
FIFO_DEPTH, 8, byte FIFO entries (power of 2).
FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
CLK  in  1  clock (XTAL1/PCLK domain).
RESETn  in  1  asynchronous active-low reset.
RXD  in  1  serial input, idle high, asynchronous to CLK.
RX_DATA  out  8  FIFO head byte.
RX_VALID  out  1  FIFO non-empty.
RX_READY  in  1  consumer pops the head when high together with RX_VALID.
FIFO_COUNT  out  FIFO_AW+1  current occupancy.
OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full.
FRAME_ERR  out  1  sticky: the stop bit sampled low.
CLR_ERR  in  1  clears both sticky flags.
DEBUG_TESTER_ENABLE  out  1  set by ESC 0x11, cleared by ESC 0x12.
SIMULATIONEND  out  1  sticky, set by ESC 0x04.

Behaviour:
- Reset: asynchronous, active-low. All outputs 0; FIFO empty; synchroniser flops = 1; FSM in IDLE; ESC flag = 0.
- Input synchroniser:
  - RXD passes through 2 flops to give rxd_s.
  - All decoding uses rxd_s.
- Receive FSM (states IDLE, START, DATA, STOP, BRK_WAIT):
  - IDLE: if rxd_s==0, go to START and load the counter with BAUD_DIV/2-1.
  - Counter: decrements every cycle. "Expiry" means the edge on which the counter equals 0; at expiry the counter reloads to BAUD_DIV-1.
  - START expiry: if rxd_s==1, treat as a glitch and return to IDLE with nothing recorded. Otherwise go to DATA with bit index 0.
  - DATA expiry: shift rxd_s in LSB first. After bit 7, go to STOP.
  - STOP expiry, rxd_s==1: byte complete, hand it to the decoder, go to IDLE.
  - STOP expiry, rxd_s==0: set FRAME_ERR, discard the byte, go to BRK_WAIT.
  - BRK_WAIT: stay until rxd_s==1, then go to IDLE. A held-low line therefore produces exactly one error.
- Latency:
  - Let k be the edge that first samples RXD low at the pin.
  - The stop sample occurs at edge k+2+BAUD_DIV/2+9*BAUD_DIV, which is 154 for BAUD_DIV=16. The FIFO write happens on that edge.
  - RX_VALID is high immediately after that edge when the FIFO was empty.
- Command decoder (acts on each completed byte):
  - ESC flag clear, byte 0x1B: set the ESC flag; nothing is pushed.
  - ESC flag clear, any other byte: push it.
  - ESC flag set, byte 0x11: DEBUG_TESTER_ENABLE=1.
  - ESC flag set, byte 0x12: DEBUG_TESTER_ENABLE=0.
  - ESC flag set, byte 0x04: SIMULATIONEND=1. It never clears except by reset.
  - ESC flag set, byte 0x1B: push a literal 0x1B.
  - ESC flag set, any other byte: push that byte; the ESC is dropped.
  - In every ESC-set case the ESC flag clears.
  - A frame error does not change the ESC flag.
- FIFO:
  - First-word-fall-through: RX_DATA = mem[rd_ptr]; RX_VALID = (count != 0).
  - Pointers are FIFO_AW wide and wrap naturally.
  - Pop when RX_VALID && RX_READY.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle (push and pop while full keeps count = DEPTH).
  - A rejected push sets OVERRUN; stored data is untouched.
  - Pop with push on an empty FIFO: only the push takes effect.
  - RX_DATA is stable while RX_VALID && !RX_READY.
- Error flags: CLR_ERR clears OVERRUN and FRAME_ERR on the next edge. If a new error occurs on the same edge, set wins.
- Reset mid-frame: everything returns to reset values and the partial byte is lost. If RXD is still low at reset release, it is treated as a new start bit.

Decomposition:
- Shared header uart_mon_defs:
  - FSM state encodings: IDLE, START, DATA, STOP, BRK_WAIT.
  - Command byte constants: ESC=8'h1B, DBG_EN=8'h11, DBG_DIS=8'h12, SIM_END=8'h04.
- One sub-module uart_mon_fifo (parameterised sync FWFT FIFO with count and overrun reporting).
- Receiver FSM and decoder stay in the top module.

Test Plan:
(All with BAUD_DIV=16.)
- Send 0x41, RX_READY=1: RX_VALID pulses for 1 cycle, 154 edges after the RXD fall, with RX_DATA=0x41; FIFO_COUNT returns to 0.
- Send 0x1B,0x11 then 0x1B,0x12 then 0x1B,0x1B then 0x1B,0x04: DEBUG_TESTER_ENABLE goes 1 then 0; FIFO holds a single 0x1B; SIMULATIONEND=1 and stays 1; no other pushes occur.
- RX_READY=0, send 9 bytes 0x00..0x08: FIFO_COUNT=8 and OVERRUN=1; draining yields 0x00..0x07; assert CLR_ERR → OVERRUN=0.
- Frame with stop bit low, then line held low for 40 bits, then 0x55: FRAME_ERR=1 exactly once; no push; 0x55 is then received correctly.
- 4-cycle low glitch on RXD: FSM returns to IDLE; no push; no error.
- Assert RESETn low midway through byte 0x3C, release, send 0xA5: only 0xA5 appears; all flags 0.
